uart_rx: RTL and testbench

UART receiver for 8N1 serial frames: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Counterpart to the design's 8N1 transmitter, at the same default 115200 baud from a 50 MHz clock.
- Synchronises the asynchronous rx line, samples each bit at its midpoint, and holds each received byte in a one-entry output register with a valid/ready handshake.
- Reports framing errors and overruns as single-cycle pulses.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions: default clocking, frame width, FSM states and
// bit-period derivation. Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned DEFAULT_CLOCK_FREQ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD_RATE  = 115_200;
  localparam int unsigned DATA_BITS          = 8;
  localparam int unsigned TICK_W             = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

  // Clock cycles per serial bit; callers must keep the result >= 4.
  function automatic int unsigned ticks_per_bit(input int unsigned clk_hz,
                                                input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; resets to a
// configurable idle level so a freshly reset line never looks like an edge.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM, one-entry holding register with a
// valid/ready handshake, and single-cycle framing-error / overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE     = DEFAULT_BAUD_RATE,
  parameter int unsigned CLOCK_FREQ    = DEFAULT_CLOCK_FREQ,
  parameter int unsigned TICKS_PER_BIT = ticks_per_bit(CLOCK_FREQ, BAUD_RATE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned HALF = TICKS_PER_BIT / 2;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(HALF - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(DATA_BITS - 1);

  logic w_rx_s;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  uart_state_t          r_state;
  logic [TICK_W-1:0]    r_tick;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tick      <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      // Consumption; a delivery later in this block overrides the clear.
      if (r_valid && data_ready)
        r_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_tick  <= '0;
          end
        end

        ST_START: begin
          if (r_tick == HALF_LAST) begin
            r_tick <= '0;
            if (!w_rx_s) begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        ST_DATA: begin
          if (r_tick == TICK_LAST) begin
            r_tick  <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx == IDX_LAST)
              r_state <= ST_STOP;
            else
              r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        ST_STOP: begin
          if (r_tick == TICK_LAST) begin
            r_tick <= '0;
            if (w_rx_s) begin
              r_state <= ST_IDLE;
              if (!r_valid || data_ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BREAK;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        // Held-low line: stay here so only one frame_err is raised.
        ST_BREAK: begin
          if (w_rx_s)
            r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a fast instance (16 ticks/bit) for functional
// cases and a default-rate instance for baud-skew tolerance.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx2 = 1'b1;
  logic       data_ready = 1'b1;
  logic       ready2 = 1'b1;
  logic [7:0] data_out, data_out2;
  logic       data_valid, frame_err, overrun;
  logic       dv2, fe2, ov2;

  uart_rx #(.TICKS_PER_BIT(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .frame_err(frame_err), .overrun(overrun)
  );

  uart_rx dut2 (
    .clk(clk), .rst(rst), .rx(rx2), .data_out(data_out2), .data_valid(dv2),
    .data_ready(ready2), .frame_err(fe2), .overrun(ov2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int valid_rise = 0, valid_hi = 0, valid_cyc = 0;
  int ferr_cnt = 0, ovr_cnt = 0, ferr2 = 0, ovr2 = 0;
  logic prev_v = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  // Monitors: pop the expected byte whenever a handshake completes.
  always @(negedge clk) begin
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    if (data_valid) valid_hi <= valid_hi + 1;
    if (data_valid && !prev_v) begin
      valid_rise <= valid_rise + 1;
      valid_cyc  <= cyc;
    end
    prev_v <= data_valid;
    if (data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_byte: got 0x%0h expected no byte", data_out);
      end else begin
        check("rx_byte", int'(data_out), int'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (fe2) ferr2 <= ferr2 + 1;
    if (ov2) ovr2  <= ovr2 + 1;
    if (dv2 && ready2) begin
      if (exp2_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_byte2: got 0x%0h expected no byte", data_out2);
      end else begin
        check("rx_byte_skew", int'(data_out2), int'(exp2_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives one frame starting just after a clock edge; period = cycles per bit.
  task automatic send(input logic [7:0] b, input logic stop, input int period, input bit line2);
    logic [9:0] f;
    f  = {stop, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      if (line2) rx2 = f[i];
      else       rx  = f[i];
      idle(period);
    end
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < limit) begin
      idle(1);
      n++;
    end
    check(name, exp_q.size() + exp2_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r0, h0, f0, o0;
    @(posedge clk); #1;
    idle(3);
    check("reset_data_out", int'(data_out), 0);
    check("reset_valid", int'(data_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    idle(5);

    // Basic frame and latency
    h0 = valid_hi;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, 16, 1'b0);
    idle(5);
    check("latency_A5", valid_cyc - t0, 155);
    check("valid_width_A5", valid_hi - h0, 1);
    check("no_ferr_A5", ferr_cnt, 0);
    check("no_ovr_A5", ovr_cnt, 0);
    drain("drain_A5", 50);

    // Short glitch on the line
    r0 = valid_rise;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(30);
    check("glitch_no_valid", valid_rise - r0, 0);
    check("glitch_no_ferr", ferr_cnt, 0);
    check("glitch_no_ovr", ovr_cnt, 0);

    // Framing error followed by a held-low break, then recovery
    r0 = valid_rise;
    f0 = ferr_cnt;
    send(8'h3C, 1'b0, 16, 1'b0);
    rx = 1'b0;
    idle(100);
    rx = 1'b1;
    idle(20);
    check("break_one_ferr", ferr_cnt - f0, 1);
    check("break_no_valid", valid_rise - r0, 0);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1, 16, 1'b0);
    idle(5);
    drain("drain_81", 50);

    // Overrun with the consumer stalled
    data_ready = 1'b0;
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1, 16, 1'b0);
    send(8'h22, 1'b1, 16, 1'b0);
    idle(5);
    check("ovr_valid_held", int'(data_valid), 1);
    check("ovr_data_held", int'(data_out), 8'h11);
    check("ovr_one_pulse", ovr_cnt - o0, 1);
    data_ready = 1'b1;
    idle(1);
    data_ready = 1'b0;
    idle(1);
    check("ovr_valid_cleared", int'(data_valid), 0);
    drain("drain_11", 10);
    data_ready = 1'b1;
    idle(20);

    // Reset in the middle of a frame
    r0 = valid_rise;
    f0 = ferr_cnt;
    fork
      send(8'hFF, 1'b1, 16, 1'b0);
      begin
        idle(60);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_data_out", int'(data_out), 0);
        check("midrst_valid", int'(data_valid), 0);
        check("midrst_frame_err", int'(frame_err), 0);
        check("midrst_overrun", int'(overrun), 0);
      end
    join
    idle(40);
    check("midrst_no_valid", valid_rise - r0, 0);
    check("midrst_no_ferr", ferr_cnt - f0, 0);
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1, 16, 1'b0);
    idle(5);
    drain("drain_5A", 50);

    // Default rate with bit period skewed about +-4%
    exp2_q.push_back(8'h00);
    send(8'h00, 1'b1, 418, 1'b1);
    idle(50);
    exp2_q.push_back(8'hFF);
    send(8'hFF, 1'b1, 450, 1'b1);
    idle(50);
    drain("drain_skew", 1000);
    check("skew_no_ferr", ferr2, 0);
    check("skew_no_ovr", ovr2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
